char_motion_fsm: RTL and testbench

Parametrised next-generation player-character motion controller for the VGA game datapath.
- Decodes two keyboard keycode slots into walk, jump and fall behaviour.
- Integrates signed velocity with gravity once per video frame.
- Clamps position to the screen and snaps to the floor on landing.
- Feeds the sprite renderer with position, velocity, facing and state.

---
 rtl/char_motion_fsm.sv | 153 +++++++++++++++
 tb/tb_char_motion_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/char_motion_fsm.sv
// char_motion_fsm: keyboard-driven walk/jump/fall controller for a sprite, updated once per video frame.
// Define CHAR_DOUBLE_JUMP_EN to allow one extra jump while airborne.
module char_motion_fsm #(
    parameter int POS_W = 10,
    parameter int VEL_W = 6,
    parameter int START_X = 320,
    parameter int START_Y = 240,
    parameter int X_MIN = 0,
    parameter int X_MAX = 639,
    parameter int WALK_SPEED = 1,
    parameter int JUMP_VEL = 8,
    parameter int GRAVITY = 1,
    parameter int MAX_FALL = 8,
    parameter logic [7:0] KEY_LEFT = 8'h04,
    parameter logic [7:0] KEY_RIGHT = 8'h07,
    parameter logic [7:0] KEY_JUMP = 8'h44
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic [7:0]       keycode0,
    input  logic [7:0]       keycode1,
    input  logic [POS_W-1:0] floor_y,
    input  logic [POS_W-1:0] char_size,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [VEL_W-1:0] vel_x,
    output logic [VEL_W-1:0] vel_y,
    output logic             facing_left,
    output logic             on_ground,
    output logic [2:0]       state_dbg
);
    localparam int SW = POS_W + 2;
    typedef logic signed [SW-1:0] sw_t;
    typedef enum logic [2:0] {RESTART = 3'd0, IDLE = 3'd1, WALK = 3'd2, RISE = 3'd3, FALL = 3'd4} state_t;
    localparam sw_t X_LO = sw_t'(X_MIN);
    localparam sw_t X_TOP = sw_t'(X_MAX + 1);
    localparam sw_t WS = sw_t'(WALK_SPEED);
    localparam sw_t G = sw_t'(GRAVITY);
    localparam sw_t MF = sw_t'(MAX_FALL);
    localparam logic [VEL_W-1:0] VJ = VEL_W'(-JUMP_VEL);

    state_t state;
    logic left, right, jump, jump_prev, jump_edge, go_l, go_r, hin, clamp, land, supported, air_jump;
    sw_t px, py, cs, fl, vy, x_hi, vx, nx, cx, rv, ry, fv_raw, fv, fy, ly;

    always_comb begin
        left = keycode0 == KEY_LEFT || keycode1 == KEY_LEFT;
        right = keycode0 == KEY_RIGHT || keycode1 == KEY_RIGHT;
        jump = keycode0 == KEY_JUMP || keycode1 == KEY_JUMP;
        go_l = left && !right;
        go_r = right && !left;
        hin = go_l || go_r;
        jump_edge = jump && !jump_prev;
        px = sw_t'({2'b00, pos_x});
        py = sw_t'({2'b00, pos_y});
        cs = sw_t'({2'b00, char_size});
        fl = sw_t'({2'b00, floor_y});
        vy = sw_t'(signed'(vel_y));
        x_hi = X_TOP - cs;
        vx = go_l ? -WS : go_r ? WS : '0;
        nx = px + vx;
        cx = nx < X_LO ? X_LO : nx > x_hi ? x_hi : nx;
        clamp = cx != nx;
        rv = vy + G;
        ry = py + rv;
        fv_raw = vy + G;
        fv = fv_raw > MF ? MF : fv_raw;
        fy = py + fv;
        land = fy + cs >= fl;
        ly = fl - cs;
        supported = py + cs >= fl;
    end

`ifdef CHAR_DOUBLE_JUMP_EN
    logic air_jump_avail;
    // Re-armed every frame spent on the ground; landing wins over a same-frame air jump.
    always_ff @(posedge CLK) begin
        if (reset) air_jump_avail <= 1'b0;
        else if (state == RESTART) air_jump_avail <= 1'b1;
        else if (frame_tick) begin
            if (state == IDLE || state == WALK || (state == FALL && land)) air_jump_avail <= 1'b1;
            else if (air_jump) air_jump_avail <= 1'b0;
        end
    end
    assign air_jump = jump_edge && air_jump_avail && (state == RISE || (state == FALL && !land));
`else
    assign air_jump = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= RESTART;
            pos_x <= POS_W'(START_X);
            pos_y <= POS_W'(START_Y);
            vel_x <= '0;
            vel_y <= '0;
            facing_left <= 1'b0;
            on_ground <= 1'b0;
            jump_prev <= 1'b0;
        end else if (state == RESTART) begin
            state <= IDLE;
            on_ground <= 1'b1;
        end else if (frame_tick) begin
            jump_prev <= jump;
            pos_x <= POS_W'(cx);
            vel_x <= clamp ? '0 : VEL_W'(vx);
            if (!clamp && hin) facing_left <= go_l;
            case (state)
                IDLE, WALK: begin
                    if (jump_edge) begin
                        state <= RISE;
                        vel_y <= VJ;
                        on_ground <= 1'b0;
                    end else if (!supported) begin
                        state <= FALL;
                        vel_y <= '0;
                        on_ground <= 1'b0;
                    end else state <= hin ? WALK : IDLE;
                end
                RISE: begin
                    if (air_jump) vel_y <= VJ;
                    else if (ry[SW-1]) begin
                        pos_y <= '0;
                        vel_y <= '0;
                        state <= FALL;
                    end else begin
                        pos_y <= POS_W'(ry);
                        vel_y <= VEL_W'(rv);
                        if (!rv[SW-1]) state <= FALL;
                    end
                end
                FALL: begin
                    if (land) begin
                        pos_y <= POS_W'(ly);
                        vel_y <= '0;
                        state <= hin ? WALK : IDLE;
                        on_ground <= 1'b1;
                    end else if (air_jump) begin
                        vel_y <= VJ;
                        state <= RISE;
                    end else begin
                        pos_y <= POS_W'(fy);
                        vel_y <= VEL_W'(fv);
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_char_motion_fsm.sv
// tb_char_motion_fsm: scoreboard bench for char_motion_fsm with default parameters.
module tb_char_motion_fsm;
    logic CLK = 1'b0, reset = 1'b1, frame_tick = 1'b0;
    logic [7:0] keycode0 = 8'h00, keycode1 = 8'h00;
    logic [9:0] floor_y = 10'd300, char_size = 10'd20;
    logic [9:0] pos_x, pos_y;
    logic [5:0] vel_x, vel_y;
    logic facing_left, on_ground;
    logic [2:0] state_dbg;

    always #5 CLK = ~CLK;

    char_motion_fsm dut (
        .CLK(CLK), .reset(reset), .frame_tick(frame_tick), .keycode0(keycode0), .keycode1(keycode1),
        .floor_y(floor_y), .char_size(char_size), .pos_x(pos_x), .pos_y(pos_y), .vel_x(vel_x),
        .vel_y(vel_y), .facing_left(facing_left), .on_ground(on_ground), .state_dbg(state_dbg)
    );

`ifdef CHAR_DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
`else
    localparam bit DJ = 1'b0;
`endif

    typedef struct {int st, x, y, vx, vy, f, g;} exp_t;
    exp_t sb[$];
    int n_checks = 0, n_fail = 0;
    int m_st, m_x, m_y, m_vx, m_vy, m_f, m_g, m_prev, m_avail;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_step(input logic [7:0] k0, input logic [7:0] k1);
        bit l, r, j, hl, hr, hin, edg;
        int vx, nx, xhi, nv, fl, cs;
        l = k0 == 8'h04 || k1 == 8'h04;
        r = k0 == 8'h07 || k1 == 8'h07;
        j = k0 == 8'h44 || k1 == 8'h44;
        hl = l && !r;
        hr = r && !l;
        hin = hl || hr;
        edg = j && !m_prev;
        m_prev = j;
        fl = floor_y;
        cs = char_size;
        vx = hl ? -1 : hr ? 1 : 0;
        nx = m_x + vx;
        xhi = 640 - cs;
        if (nx < 0) begin nx = 0; vx = 0; end
        else if (nx > xhi) begin nx = xhi; vx = 0; end
        m_x = nx;
        m_vx = vx;
        if (vx != 0) m_f = vx < 0;
        case (m_st)
            1, 2: begin
                m_avail = 1;
                if (edg) begin m_st = 3; m_vy = -8; end
                else if (m_y + cs < fl) begin m_st = 4; m_vy = 0; end
                else m_st = hin ? 2 : 1;
            end
            3: begin
                if (edg && m_avail == 1 && DJ) begin m_vy = -8; m_avail = 0; end
                else begin
                    nv = m_vy + 1;
                    if (m_y + nv < 0) begin m_y = 0; m_vy = 0; m_st = 4; end
                    else begin m_y += nv; m_vy = nv; if (nv >= 0) m_st = 4; end
                end
            end
            4: begin
                nv = m_vy + 1;
                if (nv > 8) nv = 8;
                if (m_y + nv + cs >= fl) begin m_y = fl - cs; m_vy = 0; m_st = hin ? 2 : 1; m_avail = 1; end
                else if (edg && m_avail == 1 && DJ) begin m_vy = -8; m_st = 3; m_avail = 0; end
                else begin m_y += nv; m_vy = nv; end
            end
            default: ;
        endcase
        m_g = (m_st == 1 || m_st == 2) ? 1 : 0;
    endtask

    task automatic compare_head();
        exp_t e;
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("state", int'(state_dbg), e.st);
            check("pos_x", int'(pos_x), e.x);
            check("pos_y", int'(pos_y), e.y);
            check("vel_x", int'($signed(vel_x)), e.vx);
            check("vel_y", int'($signed(vel_y)), e.vy);
            check("facing", int'(facing_left), e.f);
            check("on_ground", int'(on_ground), e.g);
        end
    endtask

    task automatic frame(input logic [7:0] k0, input logic [7:0] k1);
        exp_t e;
        @(negedge CLK);
        keycode0 = k0;
        keycode1 = k1;
        frame_tick = 1'b1;
        model_step(k0, k1);
        e = '{m_st, m_x, m_y, m_vx, m_vy, m_f, m_g};
        sb.push_back(e);
        @(negedge CLK);
        frame_tick = 1'b0;
        compare_head();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1;
        frame_tick = 1'b0;
        keycode0 = 8'h00;
        keycode1 = 8'h00;
        @(negedge CLK);
        check("rst_state", int'(state_dbg), 0);
        check("rst_x", int'(pos_x), 320);
        check("rst_y", int'(pos_y), 240);
        check("rst_vx", int'(vel_x), 0);
        check("rst_vy", int'(vel_y), 0);
        check("rst_facing", int'(facing_left), 0);
        check("rst_ground", int'(on_ground), 0);
        reset = 1'b0;
        @(negedge CLK);
        check("restart_exit", int'(state_dbg), 1);
        check("restart_ground", int'(on_ground), 1);
        m_st = 1; m_x = 320; m_y = 240; m_vx = 0; m_vy = 0; m_f = 0; m_g = 1; m_prev = 0; m_avail = 1;
    endtask

    task automatic settle();
        for (int i = 0; i < 40 && !on_ground; i++) frame(8'h00, 8'h00);
        check("settle_ground", int'(on_ground), 1);
    endtask

    initial begin
        int jumps, prev;
        do_reset();
        frame(8'h00, 8'h00);
        check("fall_y0", int'(pos_y), 240);
        check("fall_state", int'(state_dbg), 4);
        frame(8'h00, 8'h00);
        check("fall_y1", int'(pos_y), 241);
        frame(8'h00, 8'h00);
        check("fall_y2", int'(pos_y), 243);
        settle();
        check("land_y", int'(pos_y), 280);
        check("land_vy", int'(vel_y), 0);
        check("land_state", int'(state_dbg), 1);

        repeat (5) frame(8'h00, 8'h07);
        check("walk_x", int'(pos_x), 325);
        check("walk_state", int'(state_dbg), 2);
        check("walk_facing", int'(facing_left), 0);
        frame(8'h00, 8'h00);
        check("walk_release", int'(state_dbg), 1);

        jumps = 0;
        prev = state_dbg;
        for (int i = 0; i < 20; i++) begin
            frame(8'h44, 8'h00);
            if (i == 0) check("jump_vy0", int'($signed(vel_y)), -8);
            if (state_dbg == 3 && prev != 3) jumps++;
            prev = state_dbg;
        end
        check("jump_count", jumps, 1);
        check("jump_land_y", int'(pos_y), 280);
        check("jump_held_state", int'(state_dbg), 1);
        frame(8'h00, 8'h00);
        frame(8'h44, 8'h00);
        check("rejump_state", int'(state_dbg), 3);
        settle();

        frame(8'h00, 8'h07);
        repeat (6) @(negedge CLK);
        check("hold_x", int'(pos_x), m_x);
        check("hold_state", int'(state_dbg), m_st);

        for (int i = 0; i < 400 && pos_x != 0; i++) frame(8'h04, 8'h00);
        repeat (3) frame(8'h04, 8'h00);
        check("wall_l_x", int'(pos_x), 0);
        check("wall_l_vx", int'(vel_x), 0);
        check("wall_l_facing", int'(facing_left), 1);
        for (int i = 0; i < 700 && pos_x != 620; i++) frame(8'h00, 8'h07);
        repeat (2) frame(8'h07, 8'h00);
        check("wall_r_x", int'(pos_x), 620);
        check("wall_r_vx", int'(vel_x), 0);
        frame(8'h04, 8'h07);
        check("both_vx", int'(vel_x), 0);
        check("both_state", int'(state_dbg), 1);

        frame(8'h44, 8'h00);
        repeat (7) frame(8'h00, 8'h00);
        check("apex_vy", int'($signed(vel_y)), -1);
        frame(8'h44, 8'h00);
        check("air_vy", int'($signed(vel_y)), DJ ? -8 : 0);
        frame(8'h00, 8'h00);
        frame(8'h44, 8'h00);
        check("third_vy", int'($signed(vel_y)), DJ ? -6 : 2);
        settle();

        frame(8'h44, 8'h00);
        frame(8'h00, 8'h00);
        frame(8'h00, 8'h00);
        check("mid_rise", int'(state_dbg), 3);
        do_reset();
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end
endmodule
